// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, receiver states, game key scan codes
// and the 16-bit code layout handed to the register interface.
package ps2_pkg;

    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Scan codes the game reacts to; nexys4_tron_if uses the same values.
    localparam logic [7:0] KEY_SPACE = 8'h29;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_L     = 8'h4B;
    localparam logic [7:0] KEY_K     = 8'h42;

    typedef struct packed {
        logic [7:0] prefix;
        logic [7:0] scan;
    } key_code_t;

    // PS/2 uses odd parity across the data byte and the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic parity_bit);
        return ^{data_byte, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Keyboard-line and decoded-code bundle between the PS/2 port, the decoder
// and its consumer.
interface ps2_scan_decoder_if;

    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keyboard_input;
    logic        key_valid;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keyboard_input,
        input  key_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keyboard_input,
        output key_valid,
        output frame_err
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters the clock and emits a
// one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic fall,
    output logic data
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= clk_sync[1];
                cnt   <= '0;
                fall  <= level;
            end else begin
                cnt <= CW'(cnt + 1'b1);
            end
        end
    end

    assign data = data_sync[1];

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: deframes 11-bit frames and folds E0/F0 prefixes into
// a held 16-bit key code with valid and frame-error strobes.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              reset,
    ps2_scan_decoder_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] DATA   = ST_DATA;
    localparam logic [1:0] PARITY = ST_PARITY;
    localparam logic [1:0] STOP   = ST_STOP;

    logic          fall;
    logic          data;

    logic [1:0]    state,   state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg,   shreg_n;
    logic          par_q,   par_n;
    logic [TW-1:0] to_cnt,  to_cnt_n;
    logic          brk,     brk_n;
    logic          ext,     ext_n;
    logic [15:0]   code_q,  code_n;
    logic          valid_q, valid_n;
    logic          err_q,   err_n;
    key_code_t     kc;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .fall     (fall),
        .data     (data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= 1'b0;
            to_cnt  <= '0;
            brk     <= 1'b0;
            ext     <= 1'b0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shreg   <= shreg_n;
            par_q   <= par_n;
            to_cnt  <= to_cnt_n;
            brk     <= brk_n;
            ext     <= ext_n;
            code_q  <= code_n;
            valid_q <= valid_n;
            err_q   <= err_n;
        end
    end

    // Frame sequencing, byte assembly and inter-edge timeout.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_q;
        to_cnt_n  = '0;
        brk_n     = brk;
        ext_n     = ext;
        code_n    = code_q;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        kc        = '0;

        if (state != IDLE) begin
            to_cnt_n = fall ? '0 : TW'(to_cnt + 1'b1);
        end

        case (state)
            IDLE: begin
                if (fall) begin
                    if (!data) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        err_n = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shreg_n   = {data, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_n   = data;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_n = IDLE;
                    if (data && odd_parity_ok(shreg, par_q)) begin
                        if (shreg == PS2_PREFIX_BREAK) begin
                            brk_n = 1'b1;
                        end else if (shreg == PS2_PREFIX_EXT) begin
                            ext_n = 1'b1;
                        end else begin
                            // Extended breaks deliberately collapse to F0xx.
                            kc.prefix = brk ? PS2_PREFIX_BREAK : (ext ? PS2_PREFIX_EXT : 8'h00);
                            kc.scan   = shreg;
                            code_n    = kc;
                            valid_n   = 1'b1;
                            brk_n     = 1'b0;
                            ext_n     = 1'b0;
                        end
                    end else begin
                        err_n = 1'b1;
                        brk_n = 1'b0;
                        ext_n = 1'b0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if ((state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            state_n  = IDLE;
            to_cnt_n = '0;
            err_n    = 1'b1;
            brk_n    = 1'b0;
            ext_n    = 1'b0;
        end
    end

    assign bus.keyboard_input = code_q;
    assign bus.key_valid      = valid_q;
    assign bus.frame_err      = err_q;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Randomised and directed PS/2 frame stimulus checked every cycle against a
// queue-based model of the expected key codes and frame errors.
module tb_ps2_scan_decoder;
    import ps2_pkg::*;

    localparam int unsigned FILTER_LEN     = 8;
    localparam int unsigned TIMEOUT_CYCLES = 20000;
    localparam int          LAT            = FILTER_LEN + 3;

    localparam int EV_KEY = 0;
    localparam int EV_ERR = 1;
    localparam int EV_TMO = 2;

    typedef struct {
        int          kind;
        logic [15:0] code;
    } ev_t;

    logic clk;
    logic reset;
    ps2_scan_decoder_if bus();

    ps2_scan_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          failures = 0;
    int          kv_count = 0;
    int          fe_count = 0;
    int          last_fall_cyc = 0;
    ev_t         ev_q[$];
    logic [15:0] m_held = 16'h0000;
    bit          m_brk = 1'b0;
    bit          m_ext = 1'b0;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push_ev(input int kind, input logic [15:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        ev_q.push_back(e);
    endfunction

    // Protocol-level model: what one delivered byte (or a broken frame) must produce.
    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            push_ev(EV_ERR, 16'h0);
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            if (m_brk)      push_ev(EV_KEY, {8'hF0, b});
            else if (m_ext) push_ev(EV_KEY, {8'hE0, b});
            else            push_ev(EV_KEY, {8'h00, b});
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 bus.ps2_data = bits[i];
            repeat (half) @(posedge clk);
            #1 bus.ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (half) @(posedge clk);
            #1 bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        repeat (FILTER_LEN + 20) @(posedge clk);
        check(ev_q.size() == 0, name, ev_q.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int half);
        logic [10:0] bits;
        bit          par;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        model_byte(b, !(bad_par || bad_stop));
        send_bits(bits, 11, half);
        drain("drain_frame");
    endtask

    // Per-cycle compare against the model's expected events and held code.
    initial begin
        ev_t e;
        int  lat;
        forever begin
            @(negedge clk);
            if (reset) begin
                check(!(bus.key_valid && bus.frame_err), "valid_err_overlap",
                      {bus.key_valid, bus.frame_err}, 0);
                if (bus.key_valid || bus.frame_err) begin
                    if (bus.key_valid) kv_count++;
                    else fe_count++;
                    if (ev_q.size() == 0) begin
                        check(1'b0, "unexpected_event", {bus.key_valid, bus.frame_err}, 0);
                    end else begin
                        e   = ev_q.pop_front();
                        lat = cyc - last_fall_cyc;
                        if (e.kind == EV_KEY) begin
                            check(bus.key_valid, "key_kind", bus.key_valid, 1);
                            check(bus.keyboard_input == e.code, "key_code", bus.keyboard_input, e.code);
                            check(lat == LAT, "key_latency", lat, LAT);
                            m_held = e.code;
                        end else if (e.kind == EV_ERR) begin
                            check(bus.frame_err, "err_kind", bus.frame_err, 1);
                            check(lat == LAT, "err_latency", lat, LAT);
                        end else begin
                            check(bus.frame_err, "tmo_kind", bus.frame_err, 1);
                            check(lat >= int'(TIMEOUT_CYCLES) + LAT - 1 && lat <= int'(TIMEOUT_CYCLES) + LAT + 1,
                                  "tmo_latency", lat, int'(TIMEOUT_CYCLES) + LAT);
                        end
                    end
                end
                check(bus.keyboard_input == m_held, "hold", bus.keyboard_input, m_held);
            end
        end
    end

    initial begin
        int          kv0;
        int          fe0;
        logic [7:0]  b;
        int          r;
        bit          bp;
        bit          bs;

        reset        = 1'b0;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        check(bus.keyboard_input == 16'h0000, "rst_code", bus.keyboard_input, 16'h0000);
        check(bus.key_valid == 1'b0, "rst_valid", bus.key_valid, 0);
        check(bus.frame_err == 1'b0, "rst_err", bus.frame_err, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (20) @(posedge clk);

        // Plain make code
        kv0 = kv_count;
        send_frame(KEY_A, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'h001C, "make_1c", bus.keyboard_input, 16'h001C);
        check(kv_count - kv0 == 1, "make_1c_pulses", kv_count - kv0, 1);

        // Break prefix then code
        kv0 = kv_count;
        send_frame(8'hF0, 1'b0, 1'b0, 30);
        check(kv_count == kv0, "f0_no_pulse", kv_count - kv0, 0);
        send_frame(KEY_A, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'hF01C, "break_1c", bus.keyboard_input, 16'hF01C);
        check(kv_count - kv0 == 1, "break_pulses", kv_count - kv0, 1);

        // Extended make, then extended break collapsing to F0xx
        kv0 = kv_count;
        send_frame(8'hE0, 1'b0, 1'b0, 30);
        send_frame(8'h75, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'hE075, "ext_make", bus.keyboard_input, 16'hE075);
        send_frame(8'hE0, 1'b0, 1'b0, 30);
        send_frame(8'hF0, 1'b0, 1'b0, 30);
        send_frame(8'h75, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'hF075, "ext_break", bus.keyboard_input, 16'hF075);
        check(kv_count - kv0 == 2, "ext_pulses", kv_count - kv0, 2);

        // Parity error leaves the code alone, then a good frame
        fe0 = fe_count;
        send_frame(KEY_SPACE, 1'b1, 1'b0, 30);
        check(fe_count - fe0 == 1, "parity_err_pulse", fe_count - fe0, 1);
        check(bus.keyboard_input == 16'hF075, "parity_err_hold", bus.keyboard_input, 16'hF075);
        send_frame(KEY_SPACE, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'h0029, "after_parity", bus.keyboard_input, 16'h0029);

        // Stop-bit error after an E0 prefix must drop the prefix
        send_frame(8'hE0, 1'b0, 1'b0, 30);
        send_frame(KEY_K, 1'b0, 1'b1, 30);
        send_frame(KEY_K, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'h0042, "stop_err_clears_ext", bus.keyboard_input, 16'h0042);

        // Start-bit error: a lone falling edge with data high
        fe0 = fe_count;
        model_byte(8'h00, 1'b0);
        send_bits(11'h7FF, 1, 30);
        drain("drain_start_err");
        check(fe_count - fe0 == 1, "start_err_pulse", fe_count - fe0, 1);

        // Clock stalls after five data bits
        fe0 = fe_count;
        push_ev(EV_TMO, 16'h0);
        m_brk = 1'b0;
        m_ext = 1'b0;
        send_bits({2'b11, 8'h5A, 1'b0}, 6, 30);
        repeat (25000) @(posedge clk);
        check(ev_q.size() == 0, "drain_timeout", ev_q.size(), 0);
        check(fe_count - fe0 == 1, "timeout_pulse", fe_count - fe0, 1);
        send_frame(KEY_S, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'h001B, "after_timeout", bus.keyboard_input, 16'h001B);

        // Short low glitches on an idle clock line are ignored
        kv0 = kv_count;
        fe0 = fe_count;
        for (int g = 0; g < 4; g++) begin
            @(posedge clk); #1 bus.ps2_clk = 1'b0;
            repeat (5) @(posedge clk);
            #1 bus.ps2_clk = 1'b1;
            repeat (15) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        check(kv_count == kv0 && fe_count == fe0, "glitch_quiet", kv_count + fe_count - kv0 - fe0, 0);

        // Reset in mid-frame with a pending break prefix
        send_frame(8'hF0, 1'b0, 1'b0, 30);
        send_bits({2'b11, 8'hA5, 1'b0}, 4, 30);
        @(posedge clk); #1 reset = 1'b0;
        ev_q.delete();
        m_held = 16'h0000;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        repeat (3) @(negedge clk);
        check(bus.keyboard_input == 16'h0000, "midrst_code", bus.keyboard_input, 16'h0000);
        check(bus.key_valid == 1'b0, "midrst_valid", bus.key_valid, 0);
        check(bus.frame_err == 1'b0, "midrst_err", bus.frame_err, 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (30) @(posedge clk);
        send_frame(KEY_L, 1'b0, 1'b0, 30);
        check(bus.keyboard_input == 16'h004B, "after_midrst", bus.keyboard_input, 16'h004B);

        // Typematic repeat: same code, another pulse
        kv0 = kv_count;
        send_frame(KEY_L, 1'b0, 1'b0, 30);
        check(kv_count - kv0 == 1, "typematic_pulse", kv_count - kv0, 1);

        // Random traffic with prefixes and occasional corrupted frames
        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            if (r == 0)      b = 8'hE0;
            else if (r == 1) b = 8'hF0;
            else             b = 8'($urandom);
            bp = ($urandom_range(0, 9) == 0);
            bs = !bp && ($urandom_range(0, 11) == 0);
            send_frame(b, bp, bs, $urandom_range(20, 35));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
